// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Registered branch resolution stage for the execute pipeline. Evaluates a
//   RISC-V funct3 branch condition on two operands, computes the resolved next
//   PC and flags a misprediction against the front-end guess. One holding
//   register (EMPTY/FULL) with valid/ready on both sides; flush empties it.
//
//   Optional feature macro: BRU_STATS_EN (adds saturating branch/mispredict
//   counters and the stats_clr / stat_* ports).
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   flush                    drop held result, block acceptance this cycle
//   in_valid / in_ready      request handshake (in_ready is comb on out_ready, flush)
//   in_funct3                branch condition code
//   in_rs1, in_rs2           compare operands
//   in_pc, in_imm            branch PC and sign-extended offset
//   in_pred_taken/_target    front-end prediction
//   out_valid / out_ready    result handshake
//   out_taken, out_mispredict, out_illegal, out_next_pc   resolved outcome
//   stats_clr, stat_branches, stat_mispredicts            (BRU_STATS_EN only)
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_next_pc
`ifdef BRU_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  if (XLEN < 8 || STAT_W < 1) begin : g_param_chk
    $error("branch_resolve_unit: XLEN must be >= 8 and STAT_W >= 1");
  end

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state_q, state_d;

  // ---------------- condition evaluation ----------------
  logic            rs_eq, lt_s, lt_u;
  logic            taken_c, illegal_c, misp_c;
  logic [XLEN-1:0] target_c, fall_c, next_c;

  always_comb begin
    rs_eq     = (in_rs1 == in_rs2);
    lt_s      = ($signed(in_rs1) < $signed(in_rs2));
    lt_u      = (in_rs1 < in_rs2);
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (in_funct3)
      3'b000:  taken_c = rs_eq;
      3'b001:  taken_c = !rs_eq;
      3'b100:  taken_c = lt_s;
      3'b101:  taken_c = !lt_s;
      3'b110:  taken_c = lt_u;
      3'b111:  taken_c = !lt_u;
      default: illegal_c = 1'b1;
    endcase
    // Both adds wrap at 2^XLEN; carry out is intentionally dropped.
    target_c = in_pc + in_imm;
    fall_c   = in_pc + XLEN'(4);
    next_c   = taken_c ? target_c : fall_c;
    // Illegal codes force taken=0, so this reduces to pred_taken for them.
    misp_c   = (taken_c != in_pred_taken) ||
               (taken_c && in_pred_taken && (in_pred_target != target_c));
  end

  // ---------------- handshake / holding register ----------------
  logic accept;

  assign out_valid = (state_q == S_FULL);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (flush)                                  state_d = S_EMPTY;
    else if (accept)                            state_d = S_FULL;
    else if (state_q == S_FULL && out_ready)    state_d = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  logic            taken_q, taken_d;
  logic            misp_q, misp_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] npc_q, npc_d;

  // Data only moves on accept, so it is stable while stalled. Flush leaves the
  // data as-is; out_valid=0 already hides it.
  always_comb begin
    taken_d   = taken_q;
    misp_d    = misp_q;
    illegal_d = illegal_q;
    npc_d     = npc_q;
    if (accept) begin
      taken_d   = taken_c;
      misp_d    = misp_c;
      illegal_d = illegal_c;
      npc_d     = next_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q   <= 1'b0;
      misp_q    <= 1'b0;
      illegal_q <= 1'b0;
      npc_q     <= '0;
    end else begin
      taken_q   <= taken_d;
      misp_q    <= misp_d;
      illegal_q <= illegal_d;
      npc_q     <= npc_d;
    end
  end

  assign out_taken      = taken_q;
  assign out_mispredict = misp_q;
  assign out_illegal    = illegal_q;
  assign out_next_pc    = npc_q;

`ifdef BRU_STATS_EN
  // ---------------- statistics ----------------
  logic [STAT_W-1:0] br_q, br_d, mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (stats_clr) begin
      br_d = '0;
      mp_d = '0;
    end else if (accept && !illegal_c) begin
      if (!(&br_q))          br_d = br_q + 1'b1;
      if (misp_c && !(&mp_q)) mp_d = mp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32): a vector table streamed
// back-to-back, then hand-written backpressure, flush, async-reset and
// (with BRU_STATS_EN) counter sequences.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = '0;
  logic [XLEN-1:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  logic            in_pred_taken = 1'b0;
  logic [XLEN-1:0] in_pred_target = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0] out_next_pc;
`ifdef BRU_STATS_EN
  logic            stats_clr = 1'b0;
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_next_pc(out_next_pc)
`ifdef BRU_STATS_EN
    , .stats_clr(stats_clr), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pt;
    logic [31:0] ptg;
    logic        e_taken;
    logic [31:0] e_npc;
    logic        e_misp, e_ill;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_funct3      = v.f3;
    in_rs1         = v.rs1;
    in_rs2         = v.rs2;
    in_pc          = v.pc;
    in_imm         = v.imm;
    in_pred_taken  = v.pt;
    in_pred_target = v.ptg;
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, ".valid"},   64'(out_valid),      64'd1);
    chk({tag, ".taken"},   64'(out_taken),      64'(v.e_taken));
    chk({tag, ".next_pc"}, 64'(out_next_pc),    64'(v.e_npc));
    chk({tag, ".misp"},    64'(out_mispredict), 64'(v.e_misp));
    chk({tag, ".illegal"}, 64'(out_illegal),    64'(v.e_ill));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          f3      rs1           rs2           pc            imm           pt  ptg           tk  npc           mp  il
    vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h1,       32'h100,      32'h20,       1'b0, 32'h0,      1'b1, 32'h120,      1'b1, 1'b0};
    vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h1,       32'h100,      32'h20,       1'b0, 32'h0,      1'b0, 32'h104,      1'b0, 1'b0};
    vecs[2]  = '{3'b000, 32'h5,         32'h5,       32'h100,      32'h20,       1'b1, 32'h124,    1'b1, 32'h120,      1'b1, 1'b0};
    vecs[3]  = '{3'b000, 32'h5,         32'h5,       32'h100,      32'h20,       1'b1, 32'h120,    1'b1, 32'h120,      1'b0, 1'b0};
    vecs[4]  = '{3'b001, 32'h1,         32'h2,       32'hFFFF_FFFC, 32'h8,       1'b0, 32'h0,      1'b1, 32'h4,        1'b1, 1'b0};
    vecs[5]  = '{3'b001, 32'h1,         32'h1,       32'hFFFF_FFFC, 32'h8,       1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{3'b010, 32'h1,         32'h1,       32'h200,      32'h40,       1'b1, 32'h240,    1'b0, 32'h204,      1'b1, 1'b1};
    vecs[7]  = '{3'b101, 32'h8000_0000, 32'h0,       32'h300,      32'h40,       1'b0, 32'h0,      1'b0, 32'h304,      1'b0, 1'b0};
    vecs[8]  = '{3'b111, 32'h8000_0000, 32'h0,       32'h300,      32'hFFFF_FFF0, 1'b1, 32'h2F0,   1'b1, 32'h2F0,      1'b0, 1'b0};
    vecs[9]  = '{3'b101, 32'h7,         32'h7,       32'h40,       32'h10,       1'b0, 32'h0,      1'b1, 32'h50,       1'b1, 1'b0};
    vecs[10] = '{3'b011, 32'h3,         32'h9,       32'h80,       32'h10,       1'b0, 32'h0,      1'b0, 32'h84,       1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.valid",   64'(out_valid),      64'd0);
    chk("rst.taken",   64'(out_taken),      64'd0);
    chk("rst.misp",    64'(out_mispredict), 64'd0);
    chk("rst.illegal", 64'(out_illegal),    64'd0);
    chk("rst.next_pc", 64'(out_next_pc),    64'd0);
    chk("rst.in_ready", 64'(in_ready),      64'd1);
`ifdef BRU_STATS_EN
    chk("rst.stat_br", 64'(stat_branches),    64'd0);
    chk("rst.stat_mp", 64'(stat_mispredicts), 64'd0);
`endif

    // Vector table streamed back-to-back with out_ready=1
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      #1 chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 chk_out($sformatf("v%0d", i), vecs[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("drain.valid", 64'(out_valid), 64'd0);

    // Backpressure: A held for 3 cycles, then B back-to-back
    @(negedge clk);
    drive(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 chk_out("bp.accA", vecs[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) drive(vecs[4]);
      #1;
      chk($sformatf("bp.hold%0d.in_ready", k), 64'(in_ready), 64'd0);
      chk_out($sformatf("bp.hold%0d", k), vecs[0]);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp.release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 chk_out("bp.B", vecs[4]);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush with out_valid=1 and in_valid=1
    @(negedge clk);
    drive(vecs[2]); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 chk("fl.full", 64'(out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1; drive(vecs[6]); in_valid = 1'b1;
    #1 chk("fl.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 chk("fl.valid_next", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 chk($sformatf("fl.never%0d", k), 64'(out_valid), 64'd0);
    end
    chk("fl.in_ready_after", 64'(in_ready), 64'd1);

    // Async reset mid-transfer
    @(negedge clk);
    drive(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 chk("ar.full", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar.valid",   64'(out_valid),   64'd0);
    chk("ar.next_pc", 64'(out_next_pc), 64'd0);
    chk("ar.taken",   64'(out_taken),   64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ar.in_ready", 64'(in_ready), 64'd1);

`ifdef BRU_STATS_EN
    chk("st.rst_br", 64'(stat_branches),    64'd0);
    chk("st.rst_mp", 64'(stat_mispredicts), 64'd0);
    out_ready = 1'b1;
    // illegal (not counted), BEQ misp, BNE misp, BLTU correct
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      case (k)
        0: drive(vecs[6]);
        1: drive(vecs[2]);
        2: drive(vecs[4]);
        default: drive(vecs[1]);
      endcase
      in_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    chk("st.branches",    64'(stat_branches),    64'd3);
    chk("st.mispredicts", 64'(stat_mispredicts), 64'd2);
    @(negedge clk);
    stats_clr = 1'b1; drive(vecs[0]);
    @(posedge clk);
    #1;
    chk("st.clr_valid", 64'(out_valid),        64'd1);
    chk("st.clr_br",    64'(stat_branches),    64'd0);
    chk("st.clr_mp",    64'(stat_mispredicts), 64'd0);
    @(negedge clk);
    stats_clr = 1'b0; in_valid = 1'b0;
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch resolution stage for the execute pipeline. Compares two XLEN-bit operands under a RISC-V funct3 branch condition, computes the resolved next PC, and flags mispredictions against the front-end prediction. Input and output use valid/ready handshakes, and a flush input clears the stage. It sits between operand forwarding and the fetch redirect logic.

## Interface
- XLEN, 32, operand, PC and immediate width (≥ 8)
- STAT_W, 32, width of each statistics counter (used only with BRU_STATS_EN)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard the held result and block acceptance this cycle
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept this cycle
- in_funct3  in  3  branch condition code
- in_rs1, in_rs2  in  XLEN  compare operands
- in_pc  in  XLEN  branch instruction PC
- in_imm  in  XLEN  sign-extended branch offset
- in_pred_taken  in  1  front-end prediction
- in_pred_target  in  XLEN  predicted target; meaningful only if in_pred_taken
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_taken, out_mispredict, out_illegal  out  1 each  resolved outcome
- out_next_pc  out  XLEN  resolved next PC
- stats_clr  in  1  clear counters (present only with BRU_STATS_EN)
- stat_branches, stat_mispredicts  out  STAT_W  counters (present only with BRU_STATS_EN)

## Operation
- funct3 encodings: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
- Any other funct3 value:
  - taken=0, illegal=1.
  - next_pc = pc+4.
  - mispredict = pred_taken.
- Target: pc+imm modulo 2^XLEN. Fall-through: pc+4 modulo 2^XLEN. Carry out is discarded in both cases.
- next_pc = target if taken, else pc+4.
- mispredict = (taken ≠ pred_taken) OR (taken AND pred_taken AND pred_target ≠ target).
- Holding register has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- in_ready = !flush AND (!out_valid OR out_ready).
- Accept happens when in_valid AND in_ready. On accept, the register loads the new result and the state is FULL.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY when out_ready is high and there is no accept.
  - FULL→FULL when out_ready and accept occur together (back-to-back; the new result replaces the old one).
  - FULL holds unchanged while out_ready=0.
- flush forces EMPTY on the next edge and takes priority over accept and hold. The in_valid request in the flush cycle is not accepted.
- Output data fields are stable while out_valid=1 and out_ready=0.

## Timing
- Latency: 1 cycle. A request accepted at edge N is visible on out_* after edge N.
- Throughput: 1 result per cycle while out_ready=1.
- in_ready depends combinationally on out_ready and flush. There is no other input-to-output combinational path.
- Reset values:
  - out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_next_pc=0.
  - Counters = 0.
- Reset asserted mid-transfer drops the held result immediately (asynchronously). in_ready is 1 on the first cycle after release, provided flush=0.

## Configuration
- Macro: BRU_STATS_EN.
- Defined:
  - stats_clr, stat_branches and stat_mispredicts exist.
  - stat_branches increments on each accept with a legal funct3.
  - stat_mispredicts increments on each accept with mispredict=1, legal funct3 only.
  - Both counters saturate at 2^STAT_W−1.
  - stats_clr zeroes both counters on the next edge and wins over a simultaneous increment.
- Undefined: these ports and counters are absent. Datapath behaviour is identical.

## Test plan
- BLT, XLEN=32, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 → one cycle later: taken=1, next_pc=0x120, mispredict=1. BLTU with the same operands → taken=0, next_pc=0x104.
- BEQ, rs1=rs2=5, pred_taken=1, pred_target=0x124, pc=0x100, imm=0x20 → taken=1, mispredict=1 (target mismatch). With pred_target=0x120 → mispredict=0.
- Wrap-around: pc=0xFFFFFFFC, imm=0x8, BNE with 1 vs 2 → next_pc=0x4. Same pc, not taken → next_pc=0x0.
- Backpressure: hold out_ready=0 for 3 cycles after one accept → out fields stable, in_ready=0. Raise out_ready together with a new in_valid → back-to-back transfer, no bubble, no lost result.
- Flush with out_valid=1 and in_valid=1 asserted together → in_ready=0, out_valid=0 next cycle, and the flushed request never appears on the output.
- With BRU_STATS_EN: send funct3=010 plus 3 legal branches, 2 of them mispredicted → stat_branches=3, stat_mispredicts=2. Assert stats_clr together with an accept → both counters read 0.
